// File: rtl/rv32i_mem_pkg.sv
// Shared types for the program/data memory arbiter.
// - arb_state_t : arbiter mode (BOOT holds the core, RUN lets it access memory)
// - mem_owner_t : which requester owns the read response due next cycle
// - arb_gnt_t   : one-hot grant vector produced by arb_pick
package rv32i_mem_pkg;

  typedef enum logic {ARB_BOOT, ARB_RUN} arb_state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} mem_owner_t;

  typedef struct packed {
    logic flash;
    logic data;
    logic fetch;
  } arb_gnt_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant selection for the memory arbiter.
// Ports:
//   i_flash_en   - flash write request, always wins
//   i_d_req      - load/store request
//   i_if_req     - instruction fetch request
//   i_streak_hit - data has won MAX_DATA_STREAK contested cycles in a row
//   i_run        - core requests may be granted (RUN state, out of reset)
//   o_gnt        - one-hot grant {flash, data, fetch}, all zero when nothing wins
module arb_pick
  import rv32i_mem_pkg::*;
(
  input  logic     i_flash_en,
  input  logic     i_d_req,
  input  logic     i_if_req,
  input  logic     i_streak_hit,
  input  logic     i_run,
  output arb_gnt_t o_gnt
);

  always_comb begin
    o_gnt = '0;
    if (i_flash_en) begin
      o_gnt.flash = 1'b1;
    end else if (i_run) begin
      // Fetch wins over data only when data has starved it long enough.
      if (i_if_req && (i_streak_hit || !i_d_req)) begin
        o_gnt.fetch = 1'b1;
      end else if (i_d_req) begin
        o_gnt.data = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port synchronous memory between the flash loader, the core's
// instruction fetch and the core's load/store port. Holds the core (o_core_hold)
// while memory is being flashed and tags each 1-cycle read response to its issuer.
// Ports:
//   i_clk, i_rst                       - clock, synchronous active-low reset
//   i_flash_en/_addr/_data             - flash write port (never stalled)
//   i_if_req, i_if_addr                - fetch request; o_if_gnt, o_if_rvalid
//   i_d_req, i_d_we, i_d_addr, i_d_wdata - load/store request; o_d_gnt, o_d_rvalid
//   o_rdata                            - shared read return (= i_mem_rdata)
//   o_core_hold                        - core must not advance
//   o_mem_en/_we/_addr/_wdata, i_mem_rdata - memory side
module mem_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned MAX_DATA_STREAK  = 4,
  parameter int unsigned BOOT_IDLE_CYCLES = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flash_en,
  input  logic [WIDTH-1:0] i_flash_addr,
  input  logic [WIDTH-1:0] i_flash_data,
  input  logic             i_if_req,
  input  logic [WIDTH-1:0] i_if_addr,
  output logic             o_if_gnt,
  output logic             o_if_rvalid,
  input  logic             i_d_req,
  input  logic             i_d_we,
  input  logic [WIDTH-1:0] i_d_addr,
  input  logic [WIDTH-1:0] i_d_wdata,
  output logic             o_d_gnt,
  output logic             o_d_rvalid,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_core_hold,
  output logic             o_mem_en,
  output logic             o_mem_we,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0] o_mem_wdata,
  input  logic [WIDTH-1:0] i_mem_rdata
);

  localparam int unsigned IdleW   = $clog2(BOOT_IDLE_CYCLES + 1);
  localparam int unsigned StreakW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [IdleW-1:0]   IdleLast  = IdleW'(BOOT_IDLE_CYCLES - 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DATA_STREAK);

  arb_state_t          r_state;
  logic [IdleW-1:0]    r_idle;
  logic [StreakW-1:0]  r_streak;
  mem_owner_t          r_owner;

  arb_gnt_t w_gnt;
  logic     w_run;
  logic     w_streak_hit;

  // Reset is synchronous, so outputs are gated with i_rst to stay quiet during
  // the cycle reset is first asserted as well.
  assign w_run        = i_rst && (r_state == ARB_RUN);
  assign w_streak_hit = (r_streak == StreakMax);

  arb_pick u_pick (
    .i_flash_en   (i_flash_en && i_rst),
    .i_d_req      (i_d_req),
    .i_if_req     (i_if_req),
    .i_streak_hit (w_streak_hit),
    .i_run        (w_run),
    .o_gnt        (w_gnt)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state  <= ARB_BOOT;
      r_idle   <= '0;
      r_streak <= '0;
      r_owner  <= OWN_NONE;
    end else begin
      case (r_state)
        ARB_BOOT: begin
          if (i_flash_en) begin
            r_idle <= '0;
          end else if (r_idle == IdleLast) begin
            r_idle  <= '0;
            r_state <= ARB_RUN;
          end else begin
            r_idle <= r_idle + IdleW'(1);
          end
        end
        ARB_RUN: begin
          r_idle <= '0;
          if (i_flash_en) r_state <= ARB_BOOT;
        end
        default: r_state <= ARB_BOOT;
      endcase

      // Counts contested data wins; any fetch grant or idle fetch side restarts it.
      if (!i_if_req || w_gnt.fetch) begin
        r_streak <= '0;
      end else if (w_gnt.data && !w_streak_hit) begin
        r_streak <= r_streak + StreakW'(1);
      end

      if (w_gnt.fetch) begin
        r_owner <= OWN_IF;
      end else if (w_gnt.data && !i_d_we) begin
        r_owner <= OWN_D;
      end else begin
        r_owner <= OWN_NONE;
      end
    end
  end

  assign o_if_gnt    = w_gnt.fetch;
  assign o_d_gnt     = w_gnt.data;
  assign o_if_rvalid = i_rst && (r_owner == OWN_IF);
  assign o_d_rvalid  = i_rst && (r_owner == OWN_D);
  assign o_rdata     = i_mem_rdata;
  assign o_core_hold = !i_rst || (r_state == ARB_BOOT);

  assign o_mem_en    = w_gnt.flash || w_gnt.data || w_gnt.fetch;
  assign o_mem_we    = w_gnt.flash || (w_gnt.data && i_d_we);
  // With no grant the address/data still follow the data port so nothing floats.
  assign o_mem_addr  = w_gnt.flash ? i_flash_addr :
                       w_gnt.fetch ? i_if_addr    : i_d_addr;
  assign o_mem_wdata = w_gnt.flash ? i_flash_data : i_d_wdata;

endmodule
